fifo_rd_burst: RTL

FIFO_RD_BURST -- requirements
Module: fifo_rd_burst

---
 rtl/fifo_rd_burst.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_burst.sv
// Drains a programmed number of words from an async FIFO read port into a
// valid/ready stream through a 2-entry skid buffer. Optional: FIFO_RD_BURST_CHECKSUM_EN.
module fifo_rd_burst #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 9
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             start,
    input  logic [ASIZE:0]   burst_len,
    output logic             busy,
    output logic             done,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic [ASIZE:0]   word_cnt
`ifdef FIFO_RD_BURST_CHECKSUM_EN
    ,
    output logic [DSIZE-1:0] checksum
`endif
);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    localparam logic [ASIZE:0] ONE = 1;

    state_t           r_state;
    logic [ASIZE:0]   r_remaining;
    logic [ASIZE:0]   r_word_cnt;
    logic             r_busy;
    logic             r_done;
    logic [DSIZE-1:0] r_buf0;
    logic [DSIZE-1:0] r_buf1;
    logic [1:0]       r_cnt;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_cnt_nxt;

    assign w_push = (r_state == BURST) && (r_remaining != '0) && !rempty && (r_cnt != 2'd2);
    assign w_pop  = (r_cnt != 2'd0) && m_ready;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop)
            w_cnt_nxt = r_cnt + 2'd1;
        else if (w_pop && !w_push)
            w_cnt_nxt = r_cnt - 2'd1;
    end

    // Completion looks at the post-edge buffer count so done follows the last transfer by one cycle.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_word_cnt  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= BURST;
                        r_remaining <= burst_len;
                        r_word_cnt  <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                BURST: begin
                    if (r_remaining == '0 && w_cnt_nxt == 2'd0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_push) begin
                r_remaining <= r_remaining - ONE;
                r_word_cnt  <= r_word_cnt + ONE;
            end
        end
    end

    // r_buf0 is always the head; a push lands in the first free slot.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_buf0 <= '0;
            r_buf1 <= '0;
            r_cnt  <= 2'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0)
                        r_buf0 <= rdata;
                    else
                        r_buf1 <= rdata;
                end
                2'b01: r_buf0 <= r_buf1;
                2'b11: r_buf0 <= rdata;
                default: ;
            endcase
        end
    end

`ifdef FIFO_RD_BURST_CHECKSUM_EN
    logic [DSIZE-1:0] r_checksum;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)
            r_checksum <= '0;
        else if (r_state == IDLE && start)
            r_checksum <= '0;
        else if (w_pop)
            r_checksum <= r_checksum ^ r_buf0;
    end

    assign checksum = r_checksum;
`endif

    assign rinc     = w_push;
    assign busy     = r_busy;
    assign done     = r_done;
    assign m_valid  = (r_cnt != 2'd0);
    assign m_data   = r_buf0;
    assign word_cnt = r_word_cnt;

endmodule
